// File: rtl/natv_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : natv_bus_pkg
// Brief    : Shared native-bus types: slice FSM states, request struct, defaults
// Revision : 1.0 - initial release
// ============================================================================
package natv_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } natv_state_e;

    localparam logic [31:0] C_NATV_ERR_RDATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } natv_req_t;

endpackage
`default_nettype wire

// File: rtl/natv_bus_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : natv_bus_watchdog
// Brief    : Registered native-bus request slice that aborts unanswered
//            transfers with an error response after TIMEOUT_CYC cycles
// Revision : 1.0 - initial release
// ============================================================================
module natv_bus_watchdog
    import natv_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter logic [31:0] ERR_RDATA   = C_NATV_ERR_RDATA
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mstr_valid_i,
    input  logic [31:0] mstr_addr_i,
    input  logic [31:0] mstr_wdata_i,
    input  logic [3:0]  mstr_wstrb_i,
    output logic [31:0] mstr_rdata_o,
    output logic        mstr_ready_o,
    output logic        slv_valid_o,
    output logic [31:0] slv_addr_o,
    output logic [31:0] slv_wdata_o,
    output logic [3:0]  slv_wstrb_o,
    input  logic [31:0] slv_rdata_i,
    input  logic        slv_ready_i,
    input  logic        clr_i,
    output logic        err_o,
    output logic [31:0] err_addr_o,
    output logic        irq_o
);

    localparam int unsigned     CW       = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0]   C_CNT_LAST = CW'(TIMEOUT_CYC - 1);

    natv_state_e  state_q;
    natv_req_t    req_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [31:0]  rdata_q;
    logic         err_q;
    logic [31:0]  err_addr_q;
    logic         irq_q;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            if (clr_i) begin
                err_q      <= 1'b0;
                err_addr_q <= '0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (mstr_valid_i) begin
                        req_q.addr  <= mstr_addr_i;
                        req_q.wdata <= mstr_wdata_i;
                        req_q.wstrb <= mstr_wstrb_i;
                        cnt_q       <= '0;
                        state_q     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    cnt_q <= cnt_d;
                    if (slv_ready_i) begin
                        rdata_q <= slv_rdata_i;
                        state_q <= ST_RESP;
                    end else if (cnt_q == C_CNT_LAST) begin
                        rdata_q <= ERR_RDATA;
                        err_q   <= 1'b1;
                        // A same-cycle clear loses to the new timeout, so the
                        // new address must be taken even if err was already set.
                        if (!err_q || clr_i) begin
                            err_addr_q <= req_q.addr;
                        end
                        irq_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign slv_valid_o  = (state_q == ST_REQ);
    assign mstr_ready_o = (state_q == ST_RESP);
    assign mstr_rdata_o = rdata_q;
    assign slv_addr_o   = req_q.addr;
    assign slv_wdata_o  = req_q.wdata;
    assign slv_wstrb_o  = req_q.wstrb;
    assign err_o        = err_q;
    assign err_addr_o   = err_addr_q;
    assign irq_o        = irq_q;

endmodule
`default_nettype wire

// File: doc/natv_bus_watchdog.md
# natv_bus_watchdog

- Registered request slice with a response watchdog, placed directly downstream of the merged master port (the single `core_*` native bus that selects between the management core and the user masters).
- Captures each request, forwards it to the interconnect, and returns the slave's response to the master one cycle later.
- If no slave answers within `TIMEOUT_CYC` cycles, it ends the transfer with an error response. This stops the active master from stalling forever on an unmapped or hung address.

## Interface

Parameters:
- `TIMEOUT_CYC`, default 1024: cycles in REQ before abort; legal range ≥ 2.
- `ERR_RDATA`, default 32'hDEAD_BEEF: read data returned on abort.

Ports:
- `clk_i` input 1: the single clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `mstr_valid_i` input 1: request valid from the merged master.
- `mstr_addr_i` input 32: request address.
- `mstr_wdata_i` input 32: write data.
- `mstr_wstrb_i` input 4: byte strobes; 0 means read.
- `mstr_rdata_o` output 32: response data to the master.
- `mstr_ready_o` output 1: one-cycle response strobe to the master.
- `slv_valid_o` output 1: request valid to the interconnect.
- `slv_addr_o` output 32: registered address.
- `slv_wdata_o` output 32: registered write data.
- `slv_wstrb_o` output 4: registered strobes.
- `slv_rdata_i` input 32: slave read data.
- `slv_ready_i` input 1: slave response strobe.
- `clr_i` input 1: clears the sticky error.
- `err_o` output 1: sticky timeout flag.
- `err_addr_o` output 32: address of the first timed-out request since the last clear.
- `irq_o` output 1: one-cycle pulse on each timeout.

## Operation

FSM states: IDLE, REQ, RESP.

- **IDLE**
  - If `mstr_valid_i` is high: capture addr, wdata and wstrb into the `slv_*` registers, clear the counter, and go to REQ.
  - Otherwise stay in IDLE.
- **REQ**
  - `slv_valid_o`=1 and the counter increments each cycle.
  - If `slv_ready_i`=1: capture `slv_rdata_i` into the response register and go to RESP.
  - Else, if counter == `TIMEOUT_CYC`-1:
    - load `ERR_RDATA` into the response register;
    - set `err_o`;
    - latch `err_addr_o` only if `err_o` was 0;
    - pulse `irq_o`;
    - go to RESP.
- **RESP**
  - `mstr_ready_o`=1 for exactly one cycle, with `mstr_rdata_o` valid; then go to IDLE.
- Master contract: the master holds the request stable while valid and drops valid the cycle after ready. Any `mstr_valid_i` seen in IDLE is therefore a new request.
- Slave contract: a slave must not assert `slv_ready_i` unless `slv_valid_o` is high. `slv_ready_i` is ignored in IDLE and RESP.
- Response data:
  - `mstr_rdata_o` is driven only from the response register and holds its value outside RESP.
  - On write transfers, `mstr_rdata_o` carries whatever the slave returned.
- Error clear: `clr_i` clears `err_o` and `err_addr_o`. If `clr_i` and a timeout occur in the same cycle, the set wins and `err_addr_o` takes the new address.
- Counter width: $clog2(`TIMEOUT_CYC`)+1. The counter never wraps because it is cleared on entering REQ.

## Timing

- **Reset values** (`rst_i` asserted, asynchronous): every output is 0, the state is IDLE, and the counter is 0.
- **Reset mid-transfer:** the transfer is dropped with no response. The master is reset together with this block.
- **Minimum latency:**
  - `mstr_valid_i` sampled at edge 0.
  - `slv_valid_o` high after edge 0.
  - `slv_ready_i` sampled at edge 1.
  - `mstr_ready_o` high after edge 1, for one cycle.
  - Total: 2 cycles added versus a direct connection.
- **Timeout:** with no `slv_ready_i`, `slv_valid_o` is high for exactly `TIMEOUT_CYC` cycles. `mstr_ready_o` and `irq_o` are then high together in the next cycle, and `err_o` is high from that same cycle.
- **Ready on the final REQ cycle:** if `slv_ready_i` arrives on the cycle where the counter equals `TIMEOUT_CYC`-1, it is treated as a normal response. No error is raised and `irq_o` is not pulsed.
- **Back-to-back:** a new request presented in the cycle right after RESP is accepted from IDLE. The sustained rate is therefore one transfer per 3 cycles minimum.

## Structure

- Shared package `natv_bus_pkg` holds:
  - the state enum (IDLE/REQ/RESP);
  - the default `ERR_RDATA` constant;
  - a request struct (addr/wdata/wstrb), reused by later native-bus slices.
- No sub-module is natural: the counter and FSM stay inline in `natv_bus_watchdog`.

## Test plan

- **Read, slave answers in 0 wait cycles:** read to 0x0300_0000, `slv_ready_i`=1 with rdata 0x1234_5678 on the first REQ cycle -> `mstr_ready_o` 2 cycles after request, `mstr_rdata_o`=0x1234_5678, `err_o`=0.
- **Write with 5 wait cycles:** wstrb=4'b1111, wdata=0xA5A5_A5A5 -> `slv_*` match the request and are stable for 6 cycles, then one `mstr_ready_o` pulse.
- **Timeout:** `TIMEOUT_CYC`=16, slave silent, addr 0x4000_0010 -> `slv_valid_o` high for 16 cycles; `mstr_ready_o` with rdata 0xDEAD_BEEF; `irq_o` for 1 cycle; `err_o`=1; `err_addr_o`=0x4000_0010.
- **Ready on the final REQ cycle:** ready on the 16th REQ cycle -> normal data returned, `err_o`=0, no `irq_o`.
- **Sticky error, then clear:**
  - Two timeouts (0x10, then 0x20) -> `err_addr_o` stays 0x10.
  - `clr_i` asserted alone -> `err_o`=0 and `err_addr_o`=0.
  - `clr_i` asserted together with a timeout -> `err_o`=1 and `err_addr_o` holds the new address.
- **Reset in REQ:** assert `rst_i` 3 cycles into a transfer -> all outputs 0 immediately; the next request after reset completes normally.
